// File: rtl/calc_pkg.sv
// calc_pkg: shared types for the handshaked integer calculator.
//   calc_op_e    - opcode encoding carried on in_op
//   calc_state_e - top-level sequencing states
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } calc_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DIV  = 2'b01,
        DONE = 2'b10
    } calc_state_e;

endpackage

// File: rtl/calc_div_iter.sv
// calc_div_iter: iterative restoring divider, one quotient bit per cycle, MSB first.
//   clk, rst_n          - clock, synchronous active-low reset
//   start               - load operands and begin WIDTH iterations
//   dividend, divisor   - operands (divisor must be non-zero)
//   done                - high when no iteration is pending (step counter at terminal count)
//   quotient, remainder - results, valid while done is high after a run
module calc_div_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // The quotient register doubles as the dividend shifter: its MSB feeds the
    // partial remainder while the new quotient bit enters at the LSB.
    assign shifted = {remainder, quotient[WIDTH-1]};
    // Partial remainder stays below the divisor, so trial[WIDTH] is a clean sign bit.
    assign trial   = shifted - {1'b0, dsr};
    assign done    = (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            dsr       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (start) begin
            cnt       <= CW'(WIDTH);
            dsr       <= divisor;
            quotient  <= dividend;
            remainder <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (!trial[WIDTH]) begin
                remainder <= trial[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b1};
            end else begin
                remainder <= shifted[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/calc_unit.sv
// calc_unit: handshaked add/sub/mul/div calculator with registered result channel.
//   clk, rst_n                   - clock, synchronous active-low reset
//   in_valid, in_ready           - command channel handshake
//   in_a, in_b, in_op            - operands and opcode (00 add, 01 sub, 10 mul, 11 div)
//   out_valid, out_ready         - result channel handshake
//   out_result, out_rem          - result/quotient and remainder
//   out_ovf, out_dz              - carry/borrow/mul-overflow flag, divide-by-zero flag
//   busy                         - FSM not idle
//
// state | meaning
// IDLE  | no result held, ready for a command
// DIV   | divider iterating; commands refused
// DONE  | result presented; new command accepted only with out_ready
module calc_unit
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_rem,
    output logic             out_ovf,
    output logic             out_dz,
    output logic             busy
);

    calc_state_e        state;
    calc_op_e           op;
    logic               accept;
    logic               div_start;
    logic               div_done;
    logic [WIDTH-1:0]   div_q;
    logic [WIDTH-1:0]   div_r;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] prod;

    assign op        = calc_op_e'(in_op);
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign div_start = accept && (op == OP_DIV) && (in_b != '0);
    assign busy      = (state != IDLE);

    assign sum_ext = {1'b0, in_a} + {1'b0, in_b};
    assign diff    = in_a - in_b;
    assign prod    = {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};

    calc_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (in_a),
        .divisor   (in_b),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rem    <= '0;
            out_ovf    <= 1'b0;
            out_dz     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        // A new accept in DONE retires the old result on this same edge.
                        out_rem <= '0;
                        out_ovf <= 1'b0;
                        out_dz  <= 1'b0;
                        case (op)
                            OP_ADD: begin
                                out_result <= sum_ext[WIDTH-1:0];
                                out_ovf    <= sum_ext[WIDTH];
                                out_valid  <= 1'b1;
                                state      <= DONE;
                            end
                            OP_SUB: begin
                                out_result <= diff;
                                out_ovf    <= (in_a < in_b);
                                out_valid  <= 1'b1;
                                state      <= DONE;
                            end
                            OP_MUL: begin
                                out_result <= prod[WIDTH-1:0];
                                out_ovf    <= |prod[2*WIDTH-1:WIDTH];
                                out_valid  <= 1'b1;
                                state      <= DONE;
                            end
                            OP_DIV: begin
                                if (in_b == '0) begin
                                    out_result <= '1;
                                    out_rem    <= in_a;
                                    out_dz     <= 1'b1;
                                    out_valid  <= 1'b1;
                                    state      <= DONE;
                                end else begin
                                    out_result <= '0;
                                    out_valid  <= 1'b0;
                                    state      <= DIV;
                                end
                            end
                            default: ;
                        endcase
                    end else if ((state == DONE) && out_ready) begin
                        out_valid  <= 1'b0;
                        out_result <= '0;
                        out_rem    <= '0;
                        out_ovf    <= 1'b0;
                        out_dz     <= 1'b0;
                        state      <= IDLE;
                    end
                end
                DIV: begin
                    if (div_done) begin
                        out_result <= div_q;
                        out_rem    <= div_r;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
